// File: rtl/counter_sequencer.sv
// Sequencer for a load/count counter: loads a start value, counts to an end
// value, pulses done, and optionally reloads for periodic runs.
module counter_sequencer #(
    parameter int W  = 4,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          t,
    input  logic          start,
    input  logic          abort,
    input  logic          hold,
    input  logic          mode,
    input  logic [W-1:0]  ld_val,
    input  logic [W-1:0]  end_val,
    input  logic [W-1:0]  cnt_r,
    output logic          cnt_t,
    output logic          cnt_l,
    output logic          cnt_c,
    output logic [W-1:0]  cnt_i,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] runs
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   ld_sh;
    logic [W-1:0]   end_sh;
    logic           mode_sh;
    logic           aborting;

    // Abort only means something once a run is in flight.
    assign aborting = abort && (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (t) begin
            state   <= S_IDLE;
            ld_sh   <= '0;
            end_sh  <= '0;
            mode_sh <= 1'b0;
            runs    <= '0;
        end else if (aborting) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ld_sh   <= ld_val;
                        end_sh  <= end_val;
                        mode_sh <= mode;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD:  state <= S_COUNT;
                S_COUNT: begin
                    // A held cycle stays in COUNT, so each one delays done by one.
                    if (!hold && (cnt_r == end_sh)) state <= S_DONE;
                end
                S_DONE: begin
                    if (runs != '1) runs <= runs + RW'(1);
                    state <= mode_sh ? S_LOAD : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cnt_t = t || aborting;
    assign cnt_l = !t && !aborting && (state == S_LOAD);
    assign cnt_c = !t && !aborting && (state == S_COUNT) && !hold && (cnt_r != end_sh);
    assign done  = !t && !aborting && (state == S_DONE);
    assign busy  = !t && (state != S_IDLE);
    assign cnt_i = t ? '0 : ld_sh;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural 4-bit counter
// closing the cnt_r feedback loop.
module tb_counter_sequencer;

    localparam int W  = 4;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          t = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          hold = 1'b0;
    logic          mode = 1'b0;
    logic [W-1:0]  ld_val = '0;
    logic [W-1:0]  end_val = '0;
    logic [W-1:0]  cnt_r = '0;
    logic          cnt_t, cnt_l, cnt_c, busy, done;
    logic [W-1:0]  cnt_i;
    logic [RW-1:0] runs;

    int n_checks = 0;
    int n_errors = 0;
    int exp_runs = 0;
    int cyc, nc, nl;
    int hist[$];

    counter_sequencer #(.W(W), .RW(RW)) dut (
        .clk(clk), .t(t), .start(start), .abort(abort), .hold(hold),
        .mode(mode), .ld_val(ld_val), .end_val(end_val), .cnt_r(cnt_r),
        .cnt_t(cnt_t), .cnt_l(cnt_l), .cnt_c(cnt_c), .cnt_i(cnt_i),
        .busy(busy), .done(done), .runs(runs)
    );

    always #5 clk = ~clk;

    // Counter datapath model: reset > load > count, wrapping at 2^W.
    always @(posedge clk) begin
        if (cnt_t)      cnt_r <= '0;
        else if (cnt_l) cnt_r <= cnt_i;
        else if (cnt_c) cnt_r <= cnt_r + 4'd1;
    end

    // Control-exclusivity invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (!t) begin
            n_checks++;
            assert ($countones({cnt_t, cnt_l, cnt_c}) <= 1) else begin
                n_errors++;
                $error("FAIL ctrl_onehot: observed t/l/c=%b required at most one high",
                       {cnt_t, cnt_l, cnt_c});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture inputs at the next edge; returns in the LOAD cycle.
    task automatic start_run(input logic [W-1:0] ld, input logic [W-1:0] en, input logic md);
        ld_val = ld;
        end_val = en;
        mode = md;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
    endtask

    // Steps until done, counting cnt_c/cnt_l cycles and logging cnt_r in COUNT.
    task automatic wait_done(input int budget, output int cycles, output int n_c, output int n_l);
        cycles = 0;
        n_c = int'(cnt_c);
        n_l = int'(cnt_l);
        hist.delete();
        if (busy && !cnt_l && !done && !cnt_t) hist.push_back(int'(cnt_r));
        while (cycles < budget) begin
            tick();
            cycles++;
            if (done) break;
            n_c += int'(cnt_c);
            n_l += int'(cnt_l);
            if (busy && !cnt_l && !cnt_t) hist.push_back(int'(cnt_r));
        end
        check("done_within_budget", done, 1'b1);
    endtask

    initial begin
        // Reset
        #1;
        check("rst_cnt_t", cnt_t, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        tick();
        tick();
        check("rst_runs", runs, 0);
        check("rst_cnt_i", cnt_i, 0);
        t = 1'b0;
        #1;
        check("rst_release_cnt_t", cnt_t, 1'b0);
        check("idle_busy", busy, 1'b0);
        abort = 1'b1;
        #1;
        check("idle_abort_no_cnt_t", cnt_t, 1'b0);
        abort = 1'b0;
        tick();

        // One-shot 3 -> 7
        start_run(4'd3, 4'd7, 1'b0);
        check("t1_load_l", cnt_l, 1'b1);
        check("t1_load_i", cnt_i, 3);
        check("t1_load_busy", busy, 1'b1);
        check("t1_load_c", cnt_c, 1'b0);
        wait_done(40, cyc, nc, nl);
        check("t1_latency", cyc, 6);
        check("t1_pulses", nc, 4);
        check("t1_cnt_at_done", cnt_r, 7);
        check("t1_runs_in_done", runs, 0);
        tick();
        exp_runs++;
        check("t1_done_one_cycle", done, 1'b0);
        check("t1_busy_fall", busy, 1'b0);
        check("t1_runs", runs, exp_runs);

        // Wrap 14 -> 1
        start_run(4'd14, 4'd1, 1'b0);
        wait_done(40, cyc, nc, nl);
        check("t2_wrap_latency", cyc, 5);
        check("t2_wrap_pulses", nc, 3);
        check("t2_wrap_len", hist.size(), 4);
        if (hist.size() == 4) begin
            check("t2_wrap_v0", hist[0], 14);
            check("t2_wrap_v1", hist[1], 15);
            check("t2_wrap_v2", hist[2], 0);
            check("t2_wrap_v3", hist[3], 1);
        end
        tick();
        exp_runs++;

        // Zero-length 5 -> 5
        start_run(4'd5, 4'd5, 1'b0);
        wait_done(40, cyc, nc, nl);
        check("t2_zero_latency", cyc, 2);
        check("t2_zero_pulses", nc, 0);
        tick();
        exp_runs++;
        check("t2_runs", runs, exp_runs);

        // Auto-reload 0 -> 2; mode input dropped after capture
        start_run(4'd0, 4'd2, 1'b1);
        mode = 1'b0;
        wait_done(40, cyc, nc, nl);
        check("t3_first_latency", cyc, 4);
        check("t3_first_pulses", nc, 2);
        wait_done(40, cyc, nc, nl);
        check("t3_period2", cyc, 5);
        check("t3_reload_l2", nl, 1);
        wait_done(40, cyc, nc, nl);
        check("t3_period3", cyc, 5);
        check("t3_reload_l3", nl, 1);
        tick();
        exp_runs += 3;
        check("t3_runs", runs, exp_runs);
        check("t3_reloading", cnt_l, 1'b1);
        abort = 1'b1;
        #1;
        check("t3_abort_cnt_t", cnt_t, 1'b1);
        check("t3_abort_no_l", cnt_l, 1'b0);
        tick();
        abort = 1'b0;
        #1;
        check("t3_abort_idle", busy, 1'b0);
        check("t3_abort_runs", runs, exp_runs);

        // Hold for 3 cycles at cnt_r=2 in a 0 -> 4 run
        start_run(4'd0, 4'd4, 1'b0);
        tick();
        tick();
        tick();
        hold = 1'b1;
        #1;
        check("t4_hold_c", cnt_c, 1'b0);
        check("t4_hold_val0", cnt_r, 2);
        tick();
        check("t4_hold_val1", cnt_r, 2);
        tick();
        check("t4_hold_val2", cnt_r, 2);
        tick();
        hold = 1'b0;
        #1;
        check("t4_hold_val3", cnt_r, 2);
        check("t4_resume_c", cnt_c, 1'b1);
        wait_done(40, cyc, nc, nl);
        check("t4_remaining", cyc, 3);
        tick();
        exp_runs++;
        check("t4_runs", runs, exp_runs);

        // Start during COUNT ignored, then abort at cnt_r=2
        start_run(4'd0, 4'd5, 1'b0);
        tick();
        tick();
        ld_val = 4'd9;
        end_val = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("t5_start_ignored_i", cnt_i, 0);
        check("t5_cnt_at_abort", cnt_r, 2);
        abort = 1'b1;
        #1;
        check("t5_abort_cnt_t", cnt_t, 1'b1);
        check("t5_abort_no_c", cnt_c, 1'b0);
        check("t5_abort_no_done", done, 1'b0);
        tick();
        abort = 1'b0;
        #1;
        check("t5_idle_busy", busy, 1'b0);
        check("t5_cleared", cnt_r, 0);
        tick();
        check("t5_no_done", done, 1'b0);
        check("t5_runs", runs, exp_runs);

        // Reset mid-run with runs=2
        t = 1'b1;
        tick();
        t = 1'b0;
        #1;
        check("t6_runs_cleared", runs, 0);
        for (int r = 0; r < 2; r++) begin
            start_run(4'd5, 4'd5, 1'b0);
            wait_done(40, cyc, nc, nl);
            tick();
        end
        check("t6_runs2", runs, 2);
        start_run(4'd0, 4'd5, 1'b0);
        tick();
        tick();
        check("t6_in_count", cnt_c, 1'b1);
        t = 1'b1;
        #1;
        check("t6_rst_cnt_t", cnt_t, 1'b1);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_c", cnt_c, 1'b0);
        tick();
        t = 1'b0;
        #1;
        check("t6_after_busy", busy, 1'b0);
        check("t6_after_runs", runs, 0);
        check("t6_after_done", done, 1'b0);
        check("t6_after_cnt", cnt_r, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
